// File: rtl/softmax_top2_select_if.sv
// Stream-in / result-out bundle for the top-2 selector.
// master drives the element stream and ResultReady; slave is the selector.
interface softmax_top2_select_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned INPUTMAX = 2
);
  logic                Start;
  logic [INPUTMAX:0]   N;
  logic [BITWIDTH-1:0] Datain;
  logic                DatainValid;
  logic                Busy;
  logic                ResultValid;
  logic                ResultReady;
  logic [INPUTMAX-1:0] Top1Idx;
  logic [BITWIDTH-1:0] Top1Val;
  logic [INPUTMAX-1:0] Top2Idx;
  logic [BITWIDTH-1:0] Top2Val;
  logic                Top2Vld;
  logic                NanFlag;
  logic                ErrFlag;

  modport master (
    output Start, N, Datain, DatainValid, ResultReady,
    input  Busy, ResultValid, Top1Idx, Top1Val, Top2Idx, Top2Val, Top2Vld, NanFlag, ErrFlag
  );

  modport slave (
    input  Start, N, Datain, DatainValid, ResultReady,
    output Busy, ResultValid, Top1Idx, Top1Val, Top2Idx, Top2Val, Top2Vld, NanFlag, ErrFlag
  );
endinterface

// File: rtl/softmax_top2_select.sv
// Tracks the two largest IEEE-754 single values (and their indices) over one
// serial vector from the softmax stage and offers them via valid/ready.
module softmax_top2_select #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned INPUTMAX = 2
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  softmax_top2_select_if.slave         bus
);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  localparam logic [BITWIDTH-1:0] SignMask = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic [INPUTMAX:0]   Cap      = {1'b1, {INPUTMAX{1'b0}}};
  localparam logic [INPUTMAX:0]   One      = {{INPUTMAX{1'b0}}, 1'b1};

  // Unsigned-comparable key giving total numeric order; -0 folds onto +0.
  function automatic logic [BITWIDTH-1:0] order_key(input logic [BITWIDTH-1:0] x);
    logic [BITWIDTH-1:0] v;
    v = (x == SignMask) ? '0 : x;
    return v[BITWIDTH-1] ? ~v : (v | SignMask);
  endfunction

  state_e              state_q, state_d;
  logic [INPUTMAX:0]   n_q, n_d, count_q, count_d;
  logic [BITWIDTH-1:0] t1_val_q, t1_val_d, t2_val_q, t2_val_d;
  logic [INPUTMAX-1:0] t1_idx_q, t1_idx_d, t2_idx_q, t2_idx_d;
  logic                t1_vld_q, t1_vld_d, t2_vld_q, t2_vld_d;
  logic                nan_q, nan_d, err_q, err_d;
  logic [BITWIDTH-1:0] elem_key;
  logic                elem_nan, start_bad, last_elem;

  assign elem_key  = order_key(bus.Datain);
  assign elem_nan  = (bus.Datain[30:23] == 8'hFF) && (bus.Datain[22:0] != '0);
  assign start_bad = (bus.N == '0) || (bus.N > Cap);
  assign last_elem = (count_q == n_q - One);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.Start) state_d = start_bad ? StHold : StCollect;
      StCollect: if (bus.DatainValid && last_elem) state_d = StHold;
      StHold:    if (bus.ResultReady) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.Busy        = (state_q != StIdle);
    bus.ResultValid = (state_q == StHold);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      n_q      <= '0;
      count_q  <= '0;
      t1_val_q <= '0;
      t1_idx_q <= '0;
      t1_vld_q <= 1'b0;
      t2_val_q <= '0;
      t2_idx_q <= '0;
      t2_vld_q <= 1'b0;
      nan_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      n_q      <= n_d;
      count_q  <= count_d;
      t1_val_q <= t1_val_d;
      t1_idx_q <= t1_idx_d;
      t1_vld_q <= t1_vld_d;
      t2_val_q <= t2_val_d;
      t2_idx_q <= t2_idx_d;
      t2_vld_q <= t2_vld_d;
      nan_q    <= nan_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    n_d      = n_q;
    count_d  = count_q;
    t1_val_d = t1_val_q;
    t1_idx_d = t1_idx_q;
    t1_vld_d = t1_vld_q;
    t2_val_d = t2_val_q;
    t2_idx_d = t2_idx_q;
    t2_vld_d = t2_vld_q;
    nan_d    = nan_q;
    err_d    = err_q;
    if (state_q == StIdle && bus.Start) begin
      n_d      = bus.N;
      count_d  = '0;
      t1_val_d = '0;
      t1_idx_d = '0;
      t1_vld_d = 1'b0;
      t2_val_d = '0;
      t2_idx_d = '0;
      t2_vld_d = 1'b0;
      nan_d    = 1'b0;
      err_d    = start_bad;
    end else if (state_q == StCollect && bus.DatainValid) begin
      count_d = count_q + One;
      // Strict > comparisons: on ties the earlier index keeps its slot.
      if (elem_nan) begin
        nan_d = 1'b1;
      end else if (!t1_vld_q) begin
        t1_val_d = bus.Datain;
        t1_idx_d = count_q[INPUTMAX-1:0];
        t1_vld_d = 1'b1;
      end else if (elem_key > order_key(t1_val_q)) begin
        t2_val_d = t1_val_q;
        t2_idx_d = t1_idx_q;
        t2_vld_d = 1'b1;
        t1_val_d = bus.Datain;
        t1_idx_d = count_q[INPUTMAX-1:0];
      end else if (!t2_vld_q || (elem_key > order_key(t2_val_q))) begin
        t2_val_d = bus.Datain;
        t2_idx_d = count_q[INPUTMAX-1:0];
        t2_vld_d = 1'b1;
      end
    end
  end

  assign bus.Top1Idx = t1_idx_q;
  assign bus.Top1Val = t1_val_q;
  assign bus.Top2Idx = t2_idx_q;
  assign bus.Top2Val = t2_val_q;
  assign bus.Top2Vld = t2_vld_q;
  assign bus.NanFlag = nan_q;
  assign bus.ErrFlag = err_q;

endmodule

// File: tb/tb_softmax_top2_select.sv
// Directed bench: expected results queued at stimulus time, popped and
// compared by a monitor on every result handshake.
module tb_softmax_top2_select;

  typedef struct packed {
    logic [1:0]  i1;
    logic [31:0] v1;
    logic [1:0]  i2;
    logic [31:0] v2;
    logic        v2ok;
    logic        nan;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  res_t exp_q[$];

  softmax_top2_select_if #(.BITWIDTH(32), .INPUTMAX(2)) ifc ();

  softmax_top2_select #(.BITWIDTH(32), .INPUTMAX(2)) dut (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;

  function automatic res_t cur_res();
    return '{ifc.Top1Idx, ifc.Top1Val, ifc.Top2Idx, ifc.Top2Val,
             ifc.Top2Vld, ifc.NanFlag, ifc.ErrFlag};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Monitor: one pop per accepted result.
  always @(negedge clk) begin
    if (ifc.ResultValid === 1'b1 && ifc.ResultReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_result: got %h expected none", cur_res());
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result", 96'(cur_res()), 96'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [2:0] n);
    ifc.Start = 1'b1;
    ifc.N     = n;
    tick();
    ifc.Start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    ifc.Datain      = d;
    ifc.DatainValid = 1'b1;
    tick();
    ifc.DatainValid = 1'b0;
  endtask

  // Last element with latency check: valid low while it is presented, high after.
  task automatic send_last(input logic [31:0] d, input string name);
    check({name, "_rv_before"}, 96'(ifc.ResultValid), 96'(0));
    send(d);
    check({name, "_latency"}, 96'(ifc.ResultValid), 96'(1));
  endtask

  task automatic handshake(input string name);
    check({name, "_rv_hs"}, 96'(ifc.ResultValid), 96'(1));
    ifc.ResultReady = 1'b1;
    tick();
    ifc.ResultReady = 1'b0;
    check({name, "_rv_drop"}, 96'({ifc.ResultValid, ifc.Busy}), 96'(0));
  endtask

  task automatic basic_vec(input string name);
    exp_q.push_back('{2'd1, 32'h3F000000, 2'd2, 32'h3E4CCCCD, 1'b1, 1'b0, 1'b0});
    start_vec(3'd4);
    check({name, "_busy"}, 96'(ifc.Busy), 96'(1));
    send(32'h3DCCCCCD);
    send(32'h3F000000);
    send(32'h3E4CCCCD);
    send_last(32'h3E4CCCCD, name);
    handshake(name);
  endtask

  initial begin
    res_t snap;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t snap;
    ifc.Start = 1'b0; ifc.N = '0; ifc.Datain = '0;
    ifc.DatainValid = 1'b0; ifc.ResultReady = 1'b0;
    tick(); tick();
    check("reset_outputs", 96'({cur_res(), ifc.Busy, ifc.ResultValid}), 96'(0));
    rstn = 1'b1;
    tick();

    basic_vec("basic");

    // Ties with gaps, result held 5 cycles.
    exp_q.push_back('{2'd0, 32'h3E800000, 2'd1, 32'h3E800000, 1'b1, 1'b0, 1'b0});
    start_vec(3'd3);
    send(32'h3E800000);
    tick();
    send(32'h3E800000);
    tick(); tick();
    send_last(32'h3E800000, "ties");
    snap = cur_res();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_stable", 96'({cur_res(), ifc.ResultValid}), 96'({snap, 1'b1}));
    end
    handshake("ties");

    // NaN and signed zero.
    exp_q.push_back('{2'd2, 32'h80000000, 2'd3, 32'h00000000, 1'b1, 1'b1, 1'b0});
    start_vec(3'd4);
    send(32'h7FC00000);
    send(32'hBF800000);
    send(32'h80000000);
    send_last(32'h00000000, "nan");
    handshake("nan");

    // Degenerate counts.
    exp_q.push_back('{2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    start_vec(3'd0);
    check("n0_latency", 96'(ifc.ResultValid), 96'(1));
    handshake("n0");
    exp_q.push_back('{2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    start_vec(3'd5);
    check("n5_latency", 96'(ifc.ResultValid), 96'(1));
    handshake("n5");
    exp_q.push_back('{2'd0, 32'h3F800000, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0});
    start_vec(3'd1);
    send_last(32'h3F800000, "n1");
    handshake("n1");

    // Reset mid-vector.
    start_vec(3'd4);
    send(32'h3F000000);
    send(32'h3F400000);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("abort_outputs", 96'({cur_res(), ifc.Busy, ifc.ResultValid}), 96'(0));
    tick();
    check("abort_no_valid", 96'(ifc.ResultValid), 96'(0));
    basic_vec("after_reset");

    // Start and data ignore rules.
    exp_q.push_back('{2'd1, 32'h3F000000, 2'd2, 32'h3E4CCCCD, 1'b1, 1'b0, 1'b0});
    start_vec(3'd4);
    send(32'h3DCCCCCD);
    send(32'h3F000000);
    ifc.Start = 1'b1; ifc.N = 3'd1;
    tick();
    ifc.Start = 1'b0;
    send(32'h3E4CCCCD);
    send_last(32'h3E4CCCCD, "ign");
    ifc.Start = 1'b1; ifc.N = 3'd2;
    ifc.Datain = 32'h7F800000; ifc.DatainValid = 1'b1;
    tick();
    ifc.DatainValid = 1'b0;
    check("ign_hold", 96'({ifc.ResultValid, ifc.Busy}), 96'(3));
    handshake("ign");
    ifc.Start = 1'b0;
    tick();
    check("ign_no_restart", 96'(ifc.Busy), 96'(0));

    tick();
    check("queue_drained", 96'(exp_q.size()), 96'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
